ball_motion_engine: RTL and testbench
=====================================

// Module: ball_motion_engine
// PURPOSE
// Per-frame ball state owner for the quidditch playfield. On each frame_tick it tests ball/player
// overlap, and on a hit issues a request to the combinational player-ball collider (initiator side of
// the col_* interface) and applies the returned position/direction. Otherwise it integrates
// position += direction with wall bounces. Its outputs feed the renderer and score logic.
// PARAMETERS
// SCREEN_W   640  playfield width, pixels; legal x is 0..SCREEN_W-1
// SCREEN_H   480  playfield height; legal y is 0..SCREEN_H-1
// HIT_R      8    overlap radius; hit when |bx-px|<=HIT_R and |by-py|<=HIT_R
// COOLDOWN   4    frames with collision detection suppressed after an applied collision
// TIMEOUT    16   cycles to wait for col_rsp_valid before falling back
// INIT_DX    2    reset value of ball_dir_x
// INIT_DY    1    reset value of ball_dir_y
// PORTS
// clk            in   1   single clock
// rst_n          in   1   asynchronous active-low reset
// frame_tick     in   1   one-cycle pulse, once per video frame
// player_x/y     in   10  player position, unsigned
// col_req_valid  out  1   collision request valid
// col_req_ready  in   1   collider accepts request
// col_old_x/y    out  11  signed ball position snapshot (held stable while valid)
// col_old_dir_x/y out 11  signed ball direction snapshot
// col_rsp_valid  in   1   response valid
// col_new_x/y, col_new_dir_x/y in 11 signed collider result
// ball_x/y, ball_dir_x/y out 11 signed current ball state
// busy           out  1   FSM not in IDLE
// frame_overrun  out  1   one-cycle pulse: frame_tick arrived while busy (tick dropped)
// goal_left/right out 1   one-cycle goal pulses (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, rst_n=0): ball=(SCREEN_W/2,SCREEN_H/2), dir=(INIT_DX,INIT_DY), FSM=IDLE, cooldown=0,
//   all pulses/valid/busy=0, col_old_* =0. Reset mid-handshake abandons the request with no response consumed.
// - FSM: IDLE -frame_tick-> CHECK. CHECK (1 cycle): if hit && cooldown==0 -> REQ, else MOVE;
//   cooldown decrements (sat. 0) once per accepted frame_tick.
// - REQ: col_req_valid=1, col_old_* = registered ball state; stays until col_req_ready -> WAIT_RSP.
//   Snapshot must not change while valid.
// - WAIT_RSP: on col_rsp_valid load col_new_* (positions clamped to screen), cooldown=COOLDOWN -> IDLE
//   (no MOVE that frame). If TIMEOUT cycles pass first: dir_x,dir_y negated -> MOVE.
//   col_rsp_valid in the same cycle as the final timeout count wins over timeout.
// - MOVE (1 cycle): next=pos+dir in 12-bit signed. next<0 -> pos=0, dir negated;
//   next>LIMIT-1 -> pos=LIMIT-1, dir negated; each axis independent -> IDLE.
// - Negation saturates: -(-1024)=+1023. Hit test uses 12-bit signed difference of zero-extended player coords.
// - Latency: IDLE->IDLE minimum 3 cycles with no hit (tick, CHECK, MOVE); with a hit,
//   4 + ready wait + response wait cycles.
// - frame_tick in any non-IDLE state: dropped, frame_overrun pulses that cycle; FSM unaffected.
// - busy is combinational from state; col_req_valid is registered.
// CONFIGURATION
// GOAL_DETECT_EN defined: in MOVE, an x-wall hit with ball_y in [SCREEN_H/2-48, SCREEN_H/2+47]
//   pulses goal_left (x<0) or goal_right (x>W-1) for one cycle. The ball resets to centre with
//   dir=(+/-INIT_DX,INIT_DY) serving away from the scoring wall, and cooldown=COOLDOWN. No bounce that frame.
// Not defined: goal_left/right tied 0; all walls bounce.
// STRUCTURE
// - Package fq_ball_pkg: coord_t (signed [10:0]), pos12_t, FSM state enum
//   (IDLE,CHECK,REQ,WAIT_RSP,MOVE), SCREEN_* defaults, sat_neg function.
// - Sub-module ball_axis_step (pos, dir, limit -> new pos, new dir, hit_low, hit_high),
//   instantiated for x and y.
// TESTING
// 1 Reset, 1 tick, player far (0,0) -> ball (322,241), dir (2,1), busy high 2 cycles.
// 2 Ball x=638 dir_x=2, tick -> ball_x=639, dir_x=-2; dir_x=-1024 bounce -> +1023.
// 3 Player at ball position, ready held low 5 cycles then high, rsp (100,200,-3,4) ->
//   state loaded; next 4 ticks skip request.
// 4 Hit, no rsp for 16 cycles -> dir negated and moved once; rsp at cycle 16 -> rsp applied.
// 5 frame_tick during WAIT_RSP -> frame_overrun pulse, no extra update; rst_n low in REQ -> valid drops immediately.
// 6 GOAL_DETECT_EN, ball (1,240) dir (-2,0) -> goal_left pulse, ball (320,240), dir (2,1).

Source files
------------

// File: rtl/fq_ball_pkg.sv
// Shared types, playfield defaults and arithmetic helpers for the ball motion engine.
package fq_ball_pkg;

    typedef logic signed [10:0] coord_t;
    typedef logic signed [11:0] pos12_t;

    typedef enum logic [2:0] {StIdle, StCheck, StReq, StWaitRsp, StMove} state_e;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // Two's-complement negation that maps -1024 to +1023 instead of wrapping.
    function automatic coord_t sat_neg(coord_t v);
        if (v == coord_t'(11'h400)) return coord_t'(11'h3ff);
        return coord_t'(-v);
    endfunction

    function automatic coord_t clamp_pos(coord_t v, pos12_t limit);
        if (v < 0) return '0;
        if (pos12_t'(v) > limit - 12'sd1) return coord_t'(limit - 12'sd1);
        return v;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis integration step: pos + dir with clamping and direction reversal at either wall.
module ball_axis_step (
    input  logic signed [10:0] pos,
    input  logic signed [10:0] dir,
    input  logic signed [11:0] limit,
    output logic signed [10:0] new_pos,
    output logic signed [10:0] new_dir,
    output logic               hit_low,
    output logic               hit_high
);
    import fq_ball_pkg::*;

    pos12_t nxt;

    always_comb begin
        nxt      = pos12_t'(pos) + pos12_t'(dir);
        new_pos  = nxt[10:0];
        new_dir  = dir;
        hit_low  = 1'b0;
        hit_high = 1'b0;
        if (nxt < 0) begin
            new_pos = '0;
            new_dir = sat_neg(dir);
            hit_low = 1'b1;
        end else if (nxt > limit - 12'sd1) begin
            new_pos  = coord_t'(limit - 12'sd1);
            new_dir  = sat_neg(dir);
            hit_high = 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion_engine.sv
// Per-frame ball state owner: overlap test, collider handshake, wall-bounce integration.
// Define GOAL_DETECT_EN to score and re-serve on x-wall hits inside the goal mouth.
module ball_motion_engine
    import fq_ball_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int HIT_R    = 8,
    parameter int COOLDOWN = 4,
    parameter int TIMEOUT  = 16,
    parameter int INIT_DX  = 2,
    parameter int INIT_DY  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [9:0]         player_x,
    input  logic [9:0]         player_y,
    output logic               col_req_valid,
    input  logic               col_req_ready,
    output logic signed [10:0] col_old_x,
    output logic signed [10:0] col_old_y,
    output logic signed [10:0] col_old_dir_x,
    output logic signed [10:0] col_old_dir_y,
    input  logic               col_rsp_valid,
    input  logic signed [10:0] col_new_x,
    input  logic signed [10:0] col_new_y,
    input  logic signed [10:0] col_new_dir_x,
    input  logic signed [10:0] col_new_dir_y,
    output logic signed [10:0] ball_x,
    output logic signed [10:0] ball_y,
    output logic signed [10:0] ball_dir_x,
    output logic signed [10:0] ball_dir_y,
    output logic               busy,
    output logic               frame_overrun,
    output logic               goal_left,
    output logic               goal_right
);

    localparam pos12_t     LIM_X    = pos12_t'(SCREEN_W);
    localparam pos12_t     LIM_Y    = pos12_t'(SCREEN_H);
    localparam pos12_t     HIT_R12  = pos12_t'(HIT_R);
    localparam coord_t     CTR_X    = coord_t'(SCREEN_W / 2);
    localparam coord_t     CTR_Y    = coord_t'(SCREEN_H / 2);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    coord_t     bx_q, bx_d, by_q, by_d, dx_q, dx_d, dy_q, dy_d;
    coord_t     ox_q, ox_d, oy_q, oy_d, odx_q, odx_d, ody_q, ody_d;
    logic [7:0] cool_q, cool_d, tmo_q, tmo_d;
    logic       req_valid_q, req_valid_d;

    coord_t     sx_pos, sx_dir, sy_pos, sy_dir;
    logic       sx_low, sx_high, sy_low, sy_high;
    pos12_t     diff_x, diff_y;
    logic       hit, goal_hit;

    ball_axis_step u_step_x (
        .pos      (bx_q),
        .dir      (dx_q),
        .limit    (LIM_X),
        .new_pos  (sx_pos),
        .new_dir  (sx_dir),
        .hit_low  (sx_low),
        .hit_high (sx_high)
    );

    ball_axis_step u_step_y (
        .pos      (by_q),
        .dir      (dy_q),
        .limit    (LIM_Y),
        .new_pos  (sy_pos),
        .new_dir  (sy_dir),
        .hit_low  (sy_low),
        .hit_high (sy_high)
    );

    assign diff_x = pos12_t'(bx_q) - pos12_t'({2'b00, player_x});
    assign diff_y = pos12_t'(by_q) - pos12_t'({2'b00, player_y});
    assign hit    = (diff_x >= -HIT_R12) && (diff_x <= HIT_R12) &&
                    (diff_y >= -HIT_R12) && (diff_y <= HIT_R12);

`ifdef GOAL_DETECT_EN
    logic in_mouth;
    logic unused_y_hits;
    assign in_mouth      = (by_q >= coord_t'(SCREEN_H / 2 - 48)) &&
                           (by_q <= coord_t'(SCREEN_H / 2 + 47));
    assign goal_hit      = (sx_low || sx_high) && in_mouth;
    assign goal_left     = (state_q == StMove) && goal_hit && sx_low;
    assign goal_right    = (state_q == StMove) && goal_hit && sx_high;
    assign unused_y_hits = ^{sy_low, sy_high};
`else
    logic unused_hits;
    assign goal_hit    = 1'b0;
    assign goal_left   = 1'b0;
    assign goal_right  = 1'b0;
    assign unused_hits = ^{sx_low, sx_high, sy_low, sy_high};
`endif

    always_comb begin
        state_d     = state_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        odx_d       = odx_q;
        ody_d       = ody_q;
        cool_d      = cool_q;
        tmo_d       = tmo_q;
        req_valid_d = req_valid_q;
        unique case (state_q)
            StIdle: if (frame_tick) state_d = StCheck;
            StCheck: begin
                // Test uses the pre-decrement value so COOLDOWN whole frames are skipped.
                if (cool_q != 8'd0) cool_d = cool_q - 8'd1;
                if (hit && cool_q == 8'd0) begin
                    state_d     = StReq;
                    req_valid_d = 1'b1;
                    ox_d        = bx_q;
                    oy_d        = by_q;
                    odx_d       = dx_q;
                    ody_d       = dy_q;
                end else begin
                    state_d = StMove;
                end
            end
            StReq: begin
                if (col_req_ready) begin
                    req_valid_d = 1'b0;
                    tmo_d       = 8'd0;
                    state_d     = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (col_rsp_valid) begin
                    bx_d    = clamp_pos(col_new_x, LIM_X);
                    by_d    = clamp_pos(col_new_y, LIM_Y);
                    dx_d    = col_new_dir_x;
                    dy_d    = col_new_dir_y;
                    cool_d  = 8'(COOLDOWN);
                    state_d = StIdle;
                end else if (tmo_q == TMO_LAST) begin
                    dx_d    = sat_neg(dx_q);
                    dy_d    = sat_neg(dy_q);
                    state_d = StMove;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StMove: begin
                state_d = StIdle;
                if (goal_hit) begin
                    bx_d   = CTR_X;
                    by_d   = CTR_Y;
                    dx_d   = sx_low ? coord_t'(INIT_DX) : coord_t'(-INIT_DX);
                    dy_d   = coord_t'(INIT_DY);
                    cool_d = 8'(COOLDOWN);
                end else begin
                    bx_d = sx_pos;
                    by_d = sy_pos;
                    dx_d = sx_dir;
                    dy_d = sy_dir;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bx_q        <= CTR_X;
            by_q        <= CTR_Y;
            dx_q        <= coord_t'(INIT_DX);
            dy_q        <= coord_t'(INIT_DY);
            ox_q        <= '0;
            oy_q        <= '0;
            odx_q       <= '0;
            ody_q       <= '0;
            cool_q      <= '0;
            tmo_q       <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            odx_q       <= odx_d;
            ody_q       <= ody_d;
            cool_q      <= cool_d;
            tmo_q       <= tmo_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign frame_overrun = frame_tick && busy;
    assign col_req_valid = req_valid_q;
    assign col_old_x     = ox_q;
    assign col_old_y     = oy_q;
    assign col_old_dir_x = odx_q;
    assign col_old_dir_y = ody_q;
    assign ball_x        = bx_q;
    assign ball_y        = by_q;
    assign ball_dir_x    = dx_q;
    assign ball_dir_y    = dy_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: vector table of bounce cases plus handshake sequences.
module tb_ball_motion_engine;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frame_tick;
    logic [9:0]         player_x, player_y;
    logic               col_req_valid, col_req_ready, col_rsp_valid;
    logic signed [10:0] col_old_x, col_old_y, col_old_dir_x, col_old_dir_y;
    logic signed [10:0] col_new_x, col_new_y, col_new_dir_x, col_new_dir_y;
    logic signed [10:0] ball_x, ball_y, ball_dir_x, ball_dir_y;
    logic               busy, frame_overrun, goal_left, goal_right;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_motion_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .player_x      (player_x),
        .player_y      (player_y),
        .col_req_valid (col_req_valid),
        .col_req_ready (col_req_ready),
        .col_old_x     (col_old_x),
        .col_old_y     (col_old_y),
        .col_old_dir_x (col_old_dir_x),
        .col_old_dir_y (col_old_dir_y),
        .col_rsp_valid (col_rsp_valid),
        .col_new_x     (col_new_x),
        .col_new_y     (col_new_y),
        .col_new_dir_x (col_new_dir_x),
        .col_new_dir_y (col_new_dir_y),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .ball_dir_x    (ball_dir_x),
        .ball_dir_y    (ball_dir_y),
        .busy          (busy),
        .frame_overrun (frame_overrun),
        .goal_left     (goal_left),
        .goal_right    (goal_right)
    );

    typedef struct {
        int lx, ly, ldx, ldy;
        int ex, ey, edx, edy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ball(input string name, input int x, input int y, input int dx,
                              input int dy);
        check({name, "_x"}, ball_x, x);
        check({name, "_y"}, ball_y, y);
        check({name, "_dx"}, ball_dir_x, dx);
        check({name, "_dy"}, ball_dir_y, dy);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        frame_tick    = 1'b0;
        col_req_ready = 1'b0;
        col_rsp_valid = 1'b0;
        col_new_x     = '0;
        col_new_y     = '0;
        col_new_dir_x = '0;
        col_new_dir_y = '0;
        player_x      = '0;
        player_y      = '0;
        #1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Runs until the FSM returns to idle; reports busy cycles and any request seen.
    task automatic run_frame(input string name, output int cycles, output bit seen_req);
        cycles   = 0;
        seen_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            cycles++;
            seen_req |= col_req_valid;
            step();
        end
        check(name, busy, 0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            if (col_req_valid) break;
            step();
        end
        check(name, col_req_valid, 1);
    endtask

    task automatic set_rsp(input int x, input int y, input int dx, input int dy);
        col_new_x     = 11'(x);
        col_new_y     = 11'(y);
        col_new_dir_x = 11'(dx);
        col_new_dir_y = 11'(dy);
    endtask

    // From reset, start a collision with the ball at centre and leave the FSM in WAIT_RSP.
    task automatic start_collision(input string name);
        do_reset();
        player_x      = 10'd320;
        player_y      = 10'd240;
        col_req_ready = 1'b1;
        tick();
        wait_valid(name);
        step();
        col_req_ready = 1'b0;
    endtask

    task automatic load(input int x, input int y, input int dx, input int dy);
        start_collision("load_req");
        set_rsp(x, y, dx, dy);
        col_rsp_valid = 1'b1;
        step();
        col_rsp_valid = 1'b0;
        player_x      = '0;
        player_y      = '0;
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  bx, by;

        vecs[0] = '{638, 100, 2, 0, 639, 100, -2, 0};
        vecs[1] = '{500, 100, -1024, 0, 0, 100, 1023, 0};
        vecs[2] = '{10, 478, 3, 5, 13, 479, 3, -5};
        vecs[3] = '{10, 2, 0, -5, 10, 0, 0, 5};
        vecs[4] = '{100, 200, -3, 4, 97, 204, -3, 4};
        vecs[5] = '{0, 0, -1, -1, 0, 0, 1, 1};
        vecs[6] = '{700, -5, 1, 1, 639, 1, -1, 1};
        vecs[7] = '{639, 479, 1023, 1023, 639, 479, -1023, -1023};

        // Reset state and a plain frame with the player far away.
        do_reset();
        check_ball("rst", 320, 240, 2, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", col_req_valid, 0);
        check("rst_old_x", col_old_x, 0);
        check("rst_old_dx", col_old_dir_x, 0);
        check("rst_overrun", frame_overrun, 0);
        check("rst_goal", {30'd0, goal_left, goal_right}, 0);
        tick();
        run_frame("t1_idle", cyc, seen);
        check("t1_busy_cycles", cyc, 2);
        check("t1_no_req", seen, 0);
        check_ball("t1", 322, 241, 2, 1);

        // Bounce table: state loaded through the collider, then one free frame.
        foreach (vecs[i]) begin
            load(vecs[i].lx, vecs[i].ly, vecs[i].ldx, vecs[i].ldy);
            tick();
            run_frame("vec_idle", cyc, seen);
            check_ball($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].edx, vecs[i].edy);
        end

        // Backpressured request, response applied, then cooldown frames.
        do_reset();
        player_x = 10'd320;
        player_y = 10'd240;
        tick();
        wait_valid("t3_req");
        check("t3_old_x", col_old_x, 320);
        check("t3_old_y", col_old_y, 240);
        check("t3_old_dx", col_old_dir_x, 2);
        check("t3_old_dy", col_old_dir_y, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", col_req_valid, 1);
            check("t3_hold_old_x", col_old_x, 320);
        end
        col_req_ready = 1'b1;
        step();
        col_req_ready = 1'b0;
        check("t3_valid_drop", col_req_valid, 0);
        set_rsp(100, 200, -3, 4);
        col_rsp_valid = 1'b1;
        step();
        col_rsp_valid = 1'b0;
        check("t3_busy", busy, 0);
        check_ball("t3_rsp", 100, 200, -3, 4);
        bx = 100;
        by = 200;
        for (int i = 0; i < 4; i++) begin
            player_x = 10'(bx);
            player_y = 10'(by);
            tick();
            run_frame("t3_cool_idle", cyc, seen);
            check($sformatf("t3_cool_skip%0d", i), seen, 0);
            bx -= 3;
            by += 4;
        end
        check_ball("t3_after_cool", 88, 216, -3, 4);
        player_x = 10'(bx);
        player_y = 10'(by);
        tick();
        wait_valid("t3_req_again");

        // Timeout: sixteen silent WAIT_RSP cycles, late response ignored.
        start_collision("t4_req");
        repeat (16) step();
        check("t4_move_busy", busy, 1);
        set_rsp(50, 60, 7, 8);
        col_rsp_valid = 1'b1;
        step();
        col_rsp_valid = 1'b0;
        check("t4_idle", busy, 0);
        check_ball("t4_timeout", 318, 239, -2, -1);

        // Response on the last timeout cycle wins.
        start_collision("t4b_req");
        repeat (15) step();
        set_rsp(50, 60, 7, 8);
        col_rsp_valid = 1'b1;
        step();
        col_rsp_valid = 1'b0;
        check("t4b_idle", busy, 0);
        check_ball("t4b_rsp", 50, 60, 7, 8);

        // Tick during WAIT_RSP is dropped with an overrun pulse.
        start_collision("t5_req");
        frame_tick = 1'b1;
        #1;
        check("t5_overrun", frame_overrun, 1);
        step();
        frame_tick = 1'b0;
        #1;
        check("t5_overrun_end", frame_overrun, 0);
        check("t5_still_busy", busy, 1);
        set_rsp(100, 200, -3, 4);
        col_rsp_valid = 1'b1;
        step();
        col_rsp_valid = 1'b0;
        repeat (3) step();
        check("t5_idle", busy, 0);
        check_ball("t5_no_extra", 100, 200, -3, 4);

        // Reset while the request is pending.
        do_reset();
        player_x = 10'd320;
        player_y = 10'd240;
        tick();
        wait_valid("t5r_req");
        rst_n = 1'b0;
        #1;
        check("t5r_valid", col_req_valid, 0);
        check("t5r_busy", busy, 0);
        check("t5r_old_x", col_old_x, 0);
        step();
        rst_n = 1'b1;

        // Goal mouth behaviour on x-wall hits.
        load(1, 240, -2, 0);
        tick();
        step();
`ifdef GOAL_DETECT_EN
        check("t6_goal_left", goal_left, 1);
        check("t6_goal_right", goal_right, 0);
        step();
        check("t6_goal_end", goal_left, 0);
        check_ball("t6_serve", 320, 240, 2, 1);
        load(637, 200, 5, 3);
        tick();
        step();
        check("t6r_goal_right", goal_right, 1);
        check("t6r_goal_left", goal_left, 0);
        step();
        check_ball("t6r_serve", 320, 240, -2, 1);
`else
        check("t6_goal_left", goal_left, 0);
        step();
        check_ball("t6_bounce", 0, 240, 2, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
